// File: rtl/rot_cipher_pkg.sv
// ============================================================================
// rot_cipher_pkg : shared constants, state encoding and mode codes for the
//                  rotation cipher core.                       Rev 1.0
// ============================================================================
`default_nettype none

package rot_cipher_pkg;

    localparam int DEF_MSG_SIZE = 8;

    // Reference test word for the message datapath.
    localparam logic [DEF_MSG_SIZE-1:0] MSG = 8'b1001_0110;

    typedef enum logic [1:0] {
        ROT_IDLE = 2'd0,
        ROT_RUN  = 2'd1,
        ROT_DONE = 2'd2
    } rot_state_e;

    localparam logic ROT_ENC = 1'b0;
    localparam logic ROT_DEC = 1'b1;

endpackage

`default_nettype wire

// File: rtl/rot_round.sv
// ============================================================================
// rot_round : one combinational cipher round (rotate, optional key mixing
//             under ROT_CIPHER_KEY_EN).                        Rev 1.0
// ============================================================================
`default_nettype none

module rot_round
    import rot_cipher_pkg::*;
#(
    parameter int MSG_SIZE = DEF_MSG_SIZE,
    parameter int AMT_W    = (MSG_SIZE > 2) ? $clog2(MSG_SIZE) : 1
) (
    input  logic [MSG_SIZE-1:0] word,
    input  logic [AMT_W-1:0]    amt,
    input  logic                mode,
    input  logic [MSG_SIZE-1:0] key,
    output logic [MSG_SIZE-1:0] next_word
);

    logic [MSG_SIZE-1:0] src;
    logic [MSG_SIZE-1:0] rotl;
    logic [MSG_SIZE-1:0] rotr;

`ifdef ROT_CIPHER_KEY_EN
    // Decrypt strips the key before rotating so it exactly undoes encrypt.
    assign src = (mode == ROT_DEC) ? (word ^ key) : word;
`else
    logic unused_key;
    assign unused_key = ^key;
    assign src        = word;
`endif

    // amt < MSG_SIZE, so the complementary shift is 1..MSG_SIZE; a full-width
    // shift yields zero, which makes amt == 0 an identity.
    assign rotl = (src << amt) | (src >> (MSG_SIZE - int'(amt)));
    assign rotr = (src >> amt) | (src << (MSG_SIZE - int'(amt)));

`ifdef ROT_CIPHER_KEY_EN
    assign next_word = (mode == ROT_DEC) ? rotr : (rotl ^ key);
`else
    assign next_word = (mode == ROT_DEC) ? rotr : rotl;
`endif

endmodule

`default_nettype wire

// File: rtl/rot_cipher.sv
// ============================================================================
// rot_cipher : iterative rotation cipher, start/busy/done handshake, ROUNDS
//              rounds per word; key mixing via ROT_CIPHER_KEY_EN.  Rev 1.0
// ============================================================================
`default_nettype none

module rot_cipher
    import rot_cipher_pkg::*;
#(
    parameter int MSG_SIZE = DEF_MSG_SIZE,
    parameter int SHIFT_W  = 4,
    parameter int ROUNDS   = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                mode,
    input  logic [SHIFT_W-1:0]  shamt,
    input  logic [MSG_SIZE-1:0] data_in,
    input  logic [MSG_SIZE-1:0] key,
    output logic                busy,
    output logic                done,
    output logic [MSG_SIZE-1:0] out
);

    localparam int AMT_W = (MSG_SIZE > 2) ? $clog2(MSG_SIZE) : 1;
    localparam int CNT_W = $clog2(ROUNDS + 1);

    rot_state_e          state;
    rot_state_e          next_state;
    logic                mode_q;
    logic [AMT_W-1:0]    amt_q;
    logic [CNT_W-1:0]    cnt;
    logic [AMT_W-1:0]    amt_in;
    logic [MSG_SIZE-1:0] round_key;
    logic [MSG_SIZE-1:0] round_word;
    logic                capture;
    logic                last_round;

    assign amt_in     = AMT_W'(32'(shamt) % 32'(MSG_SIZE));
    assign capture    = (state == ROT_IDLE) && start;
    assign last_round = (cnt == CNT_W'(ROUNDS - 1));

    always_comb begin
        next_state = state;
        case (state)
            ROT_IDLE: if (start)      next_state = ROT_RUN;
            ROT_RUN:  if (last_round) next_state = ROT_DONE;
            ROT_DONE:                 next_state = ROT_IDLE;
            default:                  next_state = ROT_IDLE;
        endcase
    end

    // busy/done are registered from the next state so they line up with it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ROT_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= next_state;
            busy  <= (next_state == ROT_RUN);
            done  <= (next_state == ROT_DONE);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out    <= '0;
            mode_q <= ROT_ENC;
            amt_q  <= '0;
            cnt    <= '0;
        end else if (capture) begin
            out    <= data_in;
            mode_q <= mode;
            amt_q  <= amt_in;
            cnt    <= '0;
        end else if (state == ROT_RUN) begin
            out    <= round_word;
            cnt    <= cnt + CNT_W'(1);
        end
    end

`ifdef ROT_CIPHER_KEY_EN
    logic [MSG_SIZE-1:0] key_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            key_q <= '0;
        end else if (capture) begin
            key_q <= key;
        end
    end

    assign round_key = key_q;
`else
    logic unused_key;
    assign unused_key = ^key;
    assign round_key  = '0;
`endif

    rot_round #(
        .MSG_SIZE (MSG_SIZE),
        .AMT_W    (AMT_W)
    ) u_round (
        .word      (out),
        .amt       (amt_q),
        .mode      (mode_q),
        .key       (round_key),
        .next_word (round_word)
    );

endmodule

`default_nettype wire

// File: tb/tb_rot_cipher.sv
// ============================================================================
// tb_rot_cipher : vector table plus scoreboard for rot_cipher (MSG_SIZE=8,
//                 ROUNDS=4); key cases under ROT_CIPHER_KEY_EN.  Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_rot_cipher;

    localparam int MSG_SIZE = 8;
    localparam int SHIFT_W  = 4;
    localparam int ROUNDS   = 4;
`ifdef ROT_CIPHER_KEY_EN
    localparam bit KEY_EN = 1'b1;
`else
    localparam bit KEY_EN = 1'b0;
`endif

    logic                clk     = 1'b0;
    logic                reset   = 1'b0;
    logic                start   = 1'b0;
    logic                mode    = 1'b0;
    logic [SHIFT_W-1:0]  shamt   = '0;
    logic [MSG_SIZE-1:0] data_in = '0;
    logic [MSG_SIZE-1:0] key     = '0;
    logic                busy;
    logic                done;
    logic [MSG_SIZE-1:0] out;

    int n_vec = 0;
    int n_bad = 0;
    logic [MSG_SIZE-1:0] sb[$];

    always #5 clk = ~clk;

    rot_cipher #(
        .MSG_SIZE (MSG_SIZE),
        .SHIFT_W  (SHIFT_W),
        .ROUNDS   (ROUNDS)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .mode    (mode),
        .shamt   (shamt),
        .data_in (data_in),
        .key     (key),
        .busy    (busy),
        .done    (done),
        .out     (out)
    );

    typedef struct {
        logic                m;
        logic [SHIFT_W-1:0]  sa;
        logic [MSG_SIZE-1:0] d;
        logic [MSG_SIZE-1:0] k;
        logic [MSG_SIZE-1:0] exp;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Bit-position model of one round.
    function automatic logic [MSG_SIZE-1:0] ref_round(input logic [MSG_SIZE-1:0] w,
                                                      input int amt, input logic m,
                                                      input logic [MSG_SIZE-1:0] k);
        logic [MSG_SIZE-1:0] kk, src, r;
        kk  = KEY_EN ? k : '0;
        src = m ? (w ^ kk) : w;
        r   = '0;
        for (int i = 0; i < MSG_SIZE; i++) begin
            if (!m) r[(i + amt) % MSG_SIZE] = src[i];
            else    r[i] = src[(i + amt) % MSG_SIZE];
        end
        if (!m) r = r ^ kk;
        return r;
    endfunction

    function automatic logic [MSG_SIZE-1:0] ref_full(input logic m, input logic [SHIFT_W-1:0] sa,
                                                     input logic [MSG_SIZE-1:0] d,
                                                     input logic [MSG_SIZE-1:0] k);
        logic [MSG_SIZE-1:0] w;
        w = d;
        for (int r = 0; r < ROUNDS; r++) w = ref_round(w, int'(sa) % MSG_SIZE, m, k);
        return w;
    endfunction

    // One full operation; inputs are scrambled after capture, and with poke a
    // second start with other data is raised during RUN.
    task automatic run_op(input logic m, input logic [SHIFT_W-1:0] sa,
                          input logic [MSG_SIZE-1:0] d, input logic [MSG_SIZE-1:0] k,
                          input logic [MSG_SIZE-1:0] exp, input bit poke);
        logic [MSG_SIZE-1:0] model;
        logic [MSG_SIZE-1:0] sb_exp;
        int amt, cyc, busy_cnt, done_cnt;
        @(negedge clk);
        start = 1'b1; mode = m; shamt = sa; data_in = d; key = k;
        @(posedge clk); #1;
        start = 1'b0; mode = ~m; shamt = sa + 4'd3; data_in = ~d; key = ~k;
        sb.push_back(exp);
        model    = d;
        amt      = int'(sa) % MSG_SIZE;
        cyc      = 0;
        busy_cnt = (busy === 1'b1) ? 1 : 0;
        check("loaded_out", out, d);
        check("loaded_flags", {busy, done}, 2'b10);
        while (done !== 1'b1 && cyc < ROUNDS + 4) begin
            if (poke && cyc == 1) begin
                start = 1'b1; data_in = 8'hFF; shamt = 4'd2;
            end
            @(posedge clk); #1;
            start = 1'b0;
            cyc++;
            if (cyc <= ROUNDS) model = ref_round(model, amt, m, k);
            check("round_out", out, model);
            if (busy === 1'b1) busy_cnt++;
        end
        sb_exp = sb.pop_front();
        if (done !== 1'b1) begin
            n_vec++; n_bad++;
            $display("FAIL done_timeout: no done after %0d cycles, required %0d", cyc, ROUNDS);
        end else begin
            check("done_latency", cyc, ROUNDS);
            check("busy_cycles", busy_cnt, ROUNDS);
            check("busy_in_done", busy, 1'b0);
            check("scoreboard", out, sb_exp);
        end
        done_cnt = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (done === 1'b1 || busy === 1'b1) done_cnt++;
        end
        check("idle_after_done", done_cnt, 0);
        check("out_hold", out, sb_exp);
    endtask

    logic [MSG_SIZE-1:0] exp_v;
    logic [MSG_SIZE-1:0] ct;
    int                  quiet;

    initial begin
        vecs[0] = '{1'b0, 4'd1,  8'h96, 8'hA5, 8'h69};
        vecs[1] = '{1'b1, 4'd9,  8'h69, 8'h5A, 8'h96};
        vecs[2] = '{1'b0, 4'd8,  8'h96, 8'h00, 8'h96};
        vecs[3] = '{1'b0, 4'd3,  8'h3C, 8'hA5, 8'hC3};
        vecs[4] = '{1'b1, 4'd15, 8'h12, 8'h11, 8'h21};
        vecs[5] = '{1'b0, 4'd2,  8'h5B, 8'hFF, 8'h5B};
        vecs[6] = '{1'b1, 4'd0,  8'hF0, 8'h0F, 8'hF0};

        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_out", out, 8'h00);
        check("reset_flags", {busy, done}, 2'b00);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 7; i++) begin
`ifdef ROT_CIPHER_KEY_EN
            exp_v = ref_full(vecs[i].m, vecs[i].sa, vecs[i].d, vecs[i].k);
`else
            exp_v = vecs[i].exp;
`endif
            run_op(vecs[i].m, vecs[i].sa, vecs[i].d, vecs[i].k, exp_v, 1'b0);
        end

        // Start re-asserted during RUN must be ignored.
        run_op(1'b0, 4'd1, 8'h96, 8'hA5, ref_full(1'b0, 4'd1, 8'h96, 8'hA5), 1'b1);

        // Asynchronous abort in the second RUN cycle.
        @(negedge clk);
        start = 1'b1; mode = 1'b0; shamt = 4'd1; data_in = 8'h96; key = 8'h00;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        check("abort_pre_busy", busy, 1'b1);
        #1 reset = 1'b0;
        #1;
        check("abort_out", out, 8'h00);
        check("abort_flags", {busy, done}, 2'b00);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        quiet = 0;
        repeat (ROUNDS + 2) begin
            @(posedge clk); #1;
            if (busy === 1'b1 || done === 1'b1) quiet++;
        end
        check("no_resume", quiet, 0);
        check("no_resume_out", out, 8'h00);
        run_op(1'b1, 4'd9, 8'h69, 8'h00, ref_full(1'b1, 4'd9, 8'h69, 8'h00), 1'b0);

`ifdef ROT_CIPHER_KEY_EN
        run_op(1'b0, 4'd3, 8'h3C, 8'hA5, ref_full(1'b0, 4'd3, 8'h3C, 8'hA5), 1'b0);
        ct = out;
        check("key_ct_differs", (ct != 8'hC3), 1'b1);
        run_op(1'b1, 4'd3, ct, 8'hA5, 8'h3C, 1'b0);
`else
        ct = out;
        check("final_hold", ct, 8'h96);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire

// File: doc/rot_cipher.md
# rot_cipher

Iterative rotation cipher core: a parametrised successor to the fixed-width message shifter. It loads one message word on a start request and applies ROUNDS rotation rounds, one per clock. Rotation direction follows a per-operation mode (encrypt = left, decrypt = right), and each round can optionally mix in a key. It sits between the message source and the output register in the cypher datapath, with a start/busy/done handshake replacing the bare enable.

## Interface
- MSG_SIZE, default `MSG_SIZE from definitions.v (8 in bench): message width in bits, ≥2.
- SHIFT_W, default 4: width of shamt.
- ROUNDS, default 4: rounds per operation, ≥1.
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low; 0 clears all state immediately.
- start  in  1  operation request; sampled only in IDLE.
- mode  in  1  0 = encrypt (rotate left), 1 = decrypt (rotate right).
- shamt  in  SHIFT_W  rotate amount per round.
- data_in  in  MSG_SIZE  plaintext/ciphertext word.
- key  in  MSG_SIZE  round key; used only with ROT_CIPHER_KEY_EN.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse in DONE.
- out  out  MSG_SIZE  working/result register.

## Operation
- States: IDLE, RUN, DONE; 2-bit encoding.
- IDLE: if start=1, capture the following on the edge, then go to RUN:
  - data_in into out;
  - mode;
  - shamt mod MSG_SIZE into amt_q;
  - key into key_q;
  - round counter cleared to 0.
  - If start=0, hold.
- RUN: each edge applies one round to out and increments the counter. On the edge applying round ROUNDS, go to DONE.
- DONE: done=1 for exactly one cycle, out holds the result. The next edge goes to IDLE.
- start in RUN or DONE is ignored. data_in, shamt, mode and key changes after capture have no effect.
- Round without key: encrypt out ← rotl(out, amt_q); decrypt out ← rotr(out, amt_q).
- amt_q=0 (including shamt a multiple of MSG_SIZE) gives identity rounds, but the full latency still applies.
- Round counter width is clog2(ROUNDS+1). It never wraps within an operation.
- out retains its result in IDLE until the next start capture.
- Reset values: state=IDLE, out=0, busy=0, done=0, counter=0, amt_q=0, key_q=0.
- Reset asserted mid-operation aborts it. Outputs clear asynchronously and the operation does not resume.

## Timing
- Start sampled at edge k. Rounds are applied at edges k+1 … k+ROUNDS.
- busy is high from after edge k to edge k+ROUNDS.
- done is high from edge k+ROUNDS to edge k+ROUNDS+1.
- The earliest next start is sampled at edge k+ROUNDS+2. Throughput is one word per ROUNDS+2 cycles.
- busy and done are registered and mutually exclusive. Both are 0 in IDLE.

## Configuration
- ROT_CIPHER_KEY_EN defined: key mixing per round.
  - Encrypt: out ← rotl(out, amt_q) ^ key_q.
  - Decrypt: out ← rotr(out ^ key_q, amt_q).
  - Decrypt with the same key, shamt and ROUNDS inverts encrypt exactly.
- Undefined: the key port is present but ignored, key_q is not instantiated, and rounds are pure rotations.

## Structure
- definitions.v holds:
  - MSG_SIZE and the MSG test constant;
  - state encodings ROT_IDLE/ROT_RUN/ROT_DONE;
  - mode constants ROT_ENC=0, ROT_DEC=1.
- One combinational sub-module, rot_round: inputs word, amt, mode, key; output next word; contains the `ifdef ROT_CIPHER_KEY_EN`.
- rot_cipher holds only the FSM, counter and registers.

## Test plan
- Encrypt, no key, MSG_SIZE=8, ROUNDS=4, shamt=1, data_in=8'b1001_0110:
  - out=8'b0110_1001 with done at start edge +4;
  - busy high for exactly 4 cycles.
- Decrypt of 8'b0110_1001, shamt=9 (mod 8 = 1) → out=8'b1001_0110.
- Boundary: shamt=8 → out equals data_in; done still arrives after 4 rounds.
- start pulsed again during RUN with different data_in → ignored; the result matches the first operation, and only one done pulse occurs.
- reset=0 at the second RUN cycle → out, busy and done go to 0 immediately, without waiting for a clock edge. After release, a new start completes normally.
- With ROT_CIPHER_KEY_EN, key=8'hA5, shamt=3: encrypt 8'h3C, then decrypt the result → 8'h3C. The ciphertext differs from the no-key result.
